ddr_init_seq_gen: RTL
=====================

Name: ddr_init_seq_gen

Overview:
- Parametrised DDR initialisation instruction sequencer.
- Walks NUM_SEG programmable segments (weights, bias, feature maps, extra layers) and fetches one DATA_W word per instruction from an external synchronous source memory.
- Emits write instructions {last, data, addr, bl} over a valid/ready handshake with full backpressure.
- Sits between the preloaded init memories and the DDR write-command arbiter.

Parameters:
- NUM_SEG, 4, number of segments walked in index order 0..NUM_SEG-1
- DATA_W, 128, payload width
- ADDR_W, 28, DDR address width
- BL_W, 4, burst-length field width
- LEN_W, 16, per-segment length width (instruction count)
- SRC_AW, 16, source memory address width
- ADDR_STEP, 1, DDR address increment per instruction
- BL_VAL, 1, burst-length value placed in every instruction

Ports:
- clk_200M  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a sequence; ignored while busy
- seg_base  in  NUM_SEG*ADDR_W  DDR base address per segment; segment i occupies bits [i*ADDR_W +: ADDR_W]
- seg_len  in  NUM_SEG*LEN_W  instruction count per segment; 0 means the segment is skipped
- rd_en  out  1  source memory read strobe
- rd_addr  out  SRC_AW  source memory word address
- rd_data  in  DATA_W  source data, valid exactly 1 cycle after rd_en
- ins_vld  out  1  instruction valid
- ins_rdy  in  1  downstream ready
- ins  out  1+DATA_W+ADDR_W+BL_W  {last, data, addr, bl}; 161 bits at defaults
- busy  out  1  high from start acceptance until the last instruction is accepted
- init_done  out  1  level; set when the last instruction is accepted, cleared by the next accepted start

Behaviour:
- Reset: asynchronous on rst_n low. Reset values: state IDLE, rd_en=0, rd_addr=0, ins_vld=0, ins=0, busy=0, init_done=0, all counters 0, output buffer empty.
- States:
  - IDLE: on start, latch seg_base and seg_len, set seg_idx=0, inst_cnt=0, src_addr=0, busy=1, clear init_done, go to SEEK.
  - SEEK: 1 cycle. Advance seg_idx past zero-length segments. If no non-zero segment remains: go to DONE with no instructions emitted; the ins_vld=0 and init_done=1 transition is handled in DONE.
  - RUN: issue reads per the credit rule below.
  - DONE: wait until the output buffer is empty and the last instruction is accepted, then busy=0, init_done=1, return to IDLE.
- Issue rule in RUN: rd_en=1 when buffer occupancy + in-flight reads < 2. Output buffer is 2 entries.
- On each issued read:
  - rd_addr=src_addr; src_addr increments by 1 continuously across segments and wraps mod 2^SRC_AW.
  - Tag the read with addr = base[seg_idx] + inst_cnt*ADDR_STEP, truncated to ADDR_W.
  - Tag last = 1 when this is the final instruction of the final non-zero segment.
  - When inst_cnt == len[seg_idx]-1: clear inst_cnt, increment seg_idx, and re-enter SEEK; after the final instruction go to DONE instead.
- Data path: rd_data and its tag are written into the buffer on the cycle after rd_en. ins is driven from the buffer head through registers. bl = BL_VAL.
- Latency: start sampled at edge E0 → SEEK during the cycle after E0 → rd_en in the following cycle → ins_vld at E3 at the earliest.
- Handshake:
  - A transfer occurs when ins_vld && ins_rdy.
  - While ins_vld=1 and ins_rdy=0, ins holds stable.
  - No read is lost under backpressure; throughput is 1 instruction/cycle with ins_rdy held high.
- Simultaneous events:
  - Buffer push and pop in the same cycle is allowed.
  - A start arriving in the same cycle as the final acceptance is ignored (busy is still 1).
  - Descriptor input changes while busy have no effect.
- rst_n asserted mid-sequence aborts immediately to reset values. No partial state survives, and the next start restarts at segment 0.

Test Plan:
- Defaults, lens {288,8,12384,0}, bases {0,550000,600000,x}, ins_rdy=1:
  - 12680 instructions, consecutive addresses inside each segment.
  - First addr 0, first addr of segment 2 = 600000.
  - last=1 only on the 12680th instruction, whose rd_addr was 12679.
  - busy falls and init_done rises 1 cycle after that acceptance.
- Lens {3,0,0,2}, ADDR_STEP=4, bases {100,x,x,200}: instruction addrs 100,104,108,200,204; segments 1-2 skipped.
- ins_rdy driven by a random 30% duty pattern: data/addr sequence identical to the ins_rdy=1 run, ins stable while stalled, no duplicate or dropped words, rd_en never causes buffer overflow.
- All lens 0: no rd_en, no ins_vld; init_done=1 within 3 cycles of start.
- Start pulsed again while busy, and seg_len changed mid-run: sequence unaffected. Start in the final-acceptance cycle is ignored.
- rst_n pulsed low after 50 instructions: all outputs return to reset values. A new start replays from addr seg_base[0] and rd_addr 0.

Source files
------------

// File: rtl/ddr_init_seq_gen.sv
// DDR init sequencer: walks NUM_SEG segments, fetches one source word per
// instruction and emits {last,data,addr,bl} over a valid/ready handshake.
// Ports: clk_200M, rst_n (async, active-low); start, seg_base, seg_len
// descriptors; rd_en/rd_addr/rd_data source memory (1-cycle latency);
// ins_vld/ins_rdy/ins instruction stream; busy, init_done status.
module ddr_init_seq_gen #(
  parameter int NUM_SEG   = 4,
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 28,
  parameter int BL_W      = 4,
  parameter int LEN_W     = 16,
  parameter int SRC_AW    = 16,
  parameter int ADDR_STEP = 1,
  parameter int BL_VAL    = 1
) (
  input  logic                         clk_200M,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NUM_SEG*ADDR_W-1:0]    seg_base,
  input  logic [NUM_SEG*LEN_W-1:0]     seg_len,
  output logic                         rd_en,
  output logic [SRC_AW-1:0]            rd_addr,
  input  logic [DATA_W-1:0]            rd_data,
  output logic                         ins_vld,
  input  logic                         ins_rdy,
  output logic [DATA_W+ADDR_W+BL_W:0]  ins,
  output logic                         busy,
  output logic                         init_done
);

  localparam int SW = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam int IW = 1 + DATA_W + ADDR_W + BL_W;

  typedef enum logic [1:0] {
    IDLE, SEEK, RUN, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q [NUM_SEG];
  logic [LEN_W-1:0]  len_q  [NUM_SEG];
  logic [SW-1:0]     seg_idx_q, seg_idx_d;
  logic [LEN_W-1:0]  inst_cnt_q, inst_cnt_d;
  logic [SRC_AW-1:0] src_addr_q, src_addr_d;
  logic              init_done_q, init_done_d;
  logic              pend_q;
  logic              tag_last_q;
  logic [ADDR_W-1:0] tag_addr_q;
  logic [IW-1:0]     buf_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        occ_q, occ_d;

  logic              push, pop, issue;
  logic              found, more_after, seg_end;
  logic [SW-1:0]     nz_idx;
  logic [ADDR_W-1:0] cur_addr;
  logic [1:0]        credit;

  // Lowest non-empty segment at or after seg_idx, and whether any
  // non-empty segment follows the current one.
  always_comb begin
    found      = 1'b0;
    nz_idx     = '0;
    more_after = 1'b0;
    for (int j = NUM_SEG - 1; j >= 0; j--) begin
      if (SW'(j) >= seg_idx_q && len_q[j] != '0) begin
        found  = 1'b1;
        nz_idx = SW'(j);
      end
      if (SW'(j) > seg_idx_q && len_q[j] != '0)
        more_after = 1'b1;
    end
  end

  assign pop  = ins_vld & ins_rdy;
  assign push = pend_q;

  // A read slot frees up in the same cycle the head is popped, which
  // keeps one instruction per cycle flowing with a 2-entry buffer.
  assign credit = occ_q + 2'(pend_q) - 2'(pop);
  assign issue  = (state_q == RUN) && (credit < 2'd2);
  assign occ_d  = occ_q + 2'(push) - 2'(pop);

  assign seg_end  = inst_cnt_q == len_q[seg_idx_q] - LEN_W'(1);
  assign cur_addr = base_q[seg_idx_q]
                  + ADDR_W'(inst_cnt_q) * ADDR_W'(ADDR_STEP);

  always_comb begin
    state_d     = state_q;
    seg_idx_d   = seg_idx_q;
    inst_cnt_d  = inst_cnt_q;
    src_addr_d  = src_addr_q;
    init_done_d = init_done_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SEEK;
          seg_idx_d   = '0;
          inst_cnt_d  = '0;
          src_addr_d  = '0;
          init_done_d = 1'b0;
        end
      end
      SEEK: begin
        if (found) begin
          seg_idx_d = nz_idx;
          state_d   = RUN;
        end else begin
          state_d = DONE;
        end
      end
      RUN: begin
        if (issue) begin
          src_addr_d = src_addr_q + SRC_AW'(1);
          if (seg_end) begin
            inst_cnt_d = '0;
            seg_idx_d  = seg_idx_q + SW'(1);
            state_d    = more_after ? SEEK : DONE;
          end else begin
            inst_cnt_d = inst_cnt_q + LEN_W'(1);
          end
        end
      end
      DONE: begin
        if (occ_d == 2'd0) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      seg_idx_q   <= '0;
      inst_cnt_q  <= '0;
      src_addr_q  <= '0;
      init_done_q <= 1'b0;
      pend_q      <= 1'b0;
      tag_last_q  <= 1'b0;
      tag_addr_q  <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= '0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      for (int i = 0; i < NUM_SEG; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      seg_idx_q   <= seg_idx_d;
      inst_cnt_q  <= inst_cnt_d;
      src_addr_q  <= src_addr_d;
      init_done_q <= init_done_d;
      occ_q       <= occ_d;
      pend_q      <= issue;
      if (state_q == IDLE && start) begin
        for (int i = 0; i < NUM_SEG; i++) begin
          base_q[i] <= seg_base[i*ADDR_W +: ADDR_W];
          len_q[i]  <= seg_len[i*LEN_W +: LEN_W];
        end
      end
      if (issue) begin
        tag_addr_q <= cur_addr;
        tag_last_q <= seg_end && !more_after;
      end
      if (push) begin
        buf_q[wr_ptr_q] <= {tag_last_q, rd_data,
                            tag_addr_q, BL_W'(BL_VAL)};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop)
        rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign rd_en     = issue;
  assign rd_addr   = src_addr_q;
  assign ins_vld   = occ_q != 2'd0;
  assign ins       = buf_q[rd_ptr_q];
  assign busy      = state_q != IDLE;
  assign init_done = init_done_q;

endmodule
